// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle control sequencer for the single-issue RISC-V core: fetch/LSU handshakes,
// instruction latch, PC/RF write pulses, halt detection and retired-instruction count.
module riscv_multicycle_ctrl #(
   parameter int TIMEOUT   = 255,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 ifu_req_valid,
   input  logic                 ifu_req_ready,
   input  logic                 ifu_resp_valid,
   input  logic [31:0]          ifu_inst,
   output logic [31:0]          inst,
   input  logic                 dec_mem_rd,
   input  logic                 dec_mem_wr,
   input  logic                 dec_rf_wen,
   input  logic                 dec_ebreak,
   input  logic                 dec_illegal,
   output logic                 lsu_req_valid,
   input  logic                 lsu_req_ready,
   input  logic                 lsu_resp_valid,
   output logic                 rf_wen,
   output logic                 pc_wen,
   output logic                 halt,
   output logic [1:0]           halt_code,
   output logic [CNT_WIDTH-1:0] instret,
   output logic [2:0]           state
);

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      IWAIT = 3'd1,
      EXEC  = 3'd2,
      MEM   = 3'd3,
      MWAIT = 3'd4,
      WB    = 3'd5,
      HALT  = 3'd6
   } state_t;

   localparam logic [15:0]          WLAST = 16'(TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t      st;
   logic [15:0] wcnt;
   logic        in_wait, hs, expired;

   // Wait states and the handshake that lets each one advance.
   always_comb begin
      in_wait = 1'b0;
      hs      = 1'b0;
      case (st)
         FETCH:   begin in_wait = 1'b1; hs = ifu_req_ready;  end
         IWAIT:   begin in_wait = 1'b1; hs = ifu_resp_valid; end
         MEM:     begin in_wait = 1'b1; hs = lsu_req_ready;  end
         MWAIT:   begin in_wait = 1'b1; hs = lsu_resp_valid; end
         default: ;
      endcase
   end

   // A handshake in the last allowed cycle still wins over the timeout.
   assign expired = in_wait && !hs && (wcnt == WLAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st        <= FETCH;
         inst      <= '0;
         instret   <= '0;
         halt_code <= 2'b00;
         wcnt      <= '0;
      end else begin
         case (st)
            FETCH: if (ifu_req_ready) st <= IWAIT;
            IWAIT: if (ifu_resp_valid) begin
               inst <= ifu_inst;
               st   <= EXEC;
            end
            EXEC: begin
               if (dec_illegal || (dec_mem_rd && dec_mem_wr)) begin
                  st        <= HALT;
                  halt_code <= 2'b10;
               end else if (dec_ebreak) begin
                  st        <= HALT;
                  halt_code <= 2'b01;
               end else if (dec_mem_rd || dec_mem_wr) begin
                  st <= MEM;
               end else begin
                  st <= WB;
               end
            end
            MEM:   if (lsu_req_ready)  st <= MWAIT;
            MWAIT: if (lsu_resp_valid) st <= WB;
            WB: begin
               instret <= instret + ONE;
               st      <= FETCH;
            end
            HALT:    ;
            default: st <= FETCH;
         endcase
         if (expired) begin
            st        <= HALT;
            halt_code <= 2'b11;
         end
         wcnt <= (in_wait && !hs && !expired) ? wcnt + 16'd1 : 16'd0;
      end
   end

   // The fetch request is masked while reset is held so every request reads 0 in reset.
   assign ifu_req_valid = (st == FETCH) && rst;
   assign lsu_req_valid = (st == MEM);
   assign pc_wen        = (st == WB);
   assign rf_wen        = (st == WB) && dec_rf_wen;
   assign halt          = (st == HALT);
   assign state         = st;

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the single-issue RISC-V core.
- Drives fetch and load/store handshakes and latches the fetched instruction for the decoder.
- Issues one-cycle write-enable pulses to the PC register and to the 32x32 register file write port (x0 remains hardwired zero inside the register file).
- Detects halt conditions (ebreak, illegal, bus timeout) and counts retired instructions.

Parameters:
- TIMEOUT, 255: max cycles spent in any single wait state before a bus-timeout halt. Legal range 1..65535.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ifu_req_valid  out  1  fetch request; PC is taken from the PC register.
- ifu_req_ready  in  1  fetch request accepted.
- ifu_resp_valid  in  1  instruction returned.
- ifu_inst  in  32  returned instruction word.
- inst  out  32  latched instruction, fed to the decoder.
- dec_mem_rd  in  1  decoder: instruction is a load.
- dec_mem_wr  in  1  decoder: instruction is a store.
- dec_rf_wen  in  1  decoder: instruction writes rd.
- dec_ebreak  in  1  decoder: ebreak.
- dec_illegal  in  1  decoder: unsupported encoding.
- lsu_req_valid  out  1  load/store request.
- lsu_req_ready  in  1  LSU accepted the request.
- lsu_resp_valid  in  1  LSU done (load data valid / store committed).
- rf_wen  out  1  register file write enable.
- pc_wen  out  1  PC register update enable.
- halt  out  1  core halted (sticky).
- halt_code  out  2  halt cause: 00 none, 01 ebreak, 10 illegal, 11 timeout.
- instret  out  CNT_WIDTH  retired-instruction count.
- state  out  3  current FSM state, for debug.

Behaviour:
- State encoding: FETCH=0, IWAIT=1, EXEC=2, MEM=3, MWAIT=4, WB=5, HALT=6. Value 7 is unreachable; if entered, next state is FETCH.
- Reset (rst=0, asynchronous) values:
  - state=FETCH, inst=0, instret=0, halt=0, halt_code=00, wait counter=0.
  - All request and enable outputs are 0.
  - Reset mid-transaction abandons the transaction; no handshake is completed afterwards.
- Outputs are Moore: combinational from the state register only (rf_wen also uses dec_rf_wen).
- FETCH: ifu_req_valid=1. If ifu_req_ready=1 at the edge, go to IWAIT.
- IWAIT: on ifu_resp_valid=1, inst<=ifu_inst and go to EXEC. ifu_resp_valid in any other state is ignored.
- EXEC: one cycle; the decoder evaluates inst. Priority, highest first:
  - dec_illegal, or dec_mem_rd&dec_mem_wr both set: go to HALT, code 10.
  - dec_ebreak: go to HALT, code 01.
  - dec_mem_rd|dec_mem_wr: go to MEM.
  - otherwise: go to WB.
- MEM: lsu_req_valid=1. On lsu_req_ready, go to MWAIT.
- MWAIT: on lsu_resp_valid, go to WB.
- WB, exactly one cycle:
  - pc_wen=1.
  - rf_wen=dec_rf_wen (stores and branches have dec_rf_wen=0).
  - instret<=instret+1, wrapping modulo 2^CNT_WIDTH.
  - Next state FETCH.
- Fetch latency: fastest instruction is 4 cycles (FETCH, IWAIT, EXEC, WB) with ready/resp asserted immediately. Loads and stores take at least 6 cycles.
- Timeout:
  - The wait counter increments each cycle spent in FETCH, IWAIT, MEM or MWAIT without the advancing handshake.
  - It clears on every state transition.
  - When the counter equals TIMEOUT-1 and the handshake is still absent, the next state is HALT with code 11.
  - A handshake arriving in that same cycle wins: the normal transition is taken.
- HALT:
  - Sticky until reset. halt=1, halt_code held.
  - No requests, pc_wen=0, rf_wen=0. instret frozen.
- halt_code is written only on entry to HALT.

Test Plan:
- ALU instruction (dec_rf_wen=1), ready/resp immediate: state sequence 0,1,2,5,0; rf_wen and pc_wen high for exactly cycle 4 only; instret 0 -> 1; inst = ifu_inst (e.g. 0x00100093).
- Load with lsu_req_ready delayed 3 cycles and lsu_resp_valid delayed 2 more: lsu_req_valid held 4 cycles; sequence reaches WB after 9 cycles total; single rf_wen pulse. Store variant: rf_wen=0, pc_wen=1.
- dec_ebreak in EXEC: halt=1, halt_code=01 from the next cycle. Further ready/resp pulses produce no requests; instret unchanged.
- dec_illegal together with dec_ebreak: halt_code=10. dec_mem_rd=dec_mem_wr=1: halt_code=10.
- TIMEOUT=8, ifu_resp_valid never asserted: HALT entered exactly 8 cycles after IWAIT entry with code 11. Separately, resp arriving in the 8th cycle yields EXEC, not HALT.
- rst pulled low while in MWAIT: all outputs return to reset values immediately (asynchronously). After release, FETCH with ifu_req_valid=1. A stale lsu_resp_valid after release is ignored. instret preload 0xFFFFFFFF plus one retire gives 0.
